// File: rtl/stream_demux_n.sv
// Routes one valid/ready input stream to one of N output channels or broadcasts to all,
// with a one-entry register per channel and a saturating counter for out-of-range selects.
module stream_demux_n #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = 2,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [SW-1:0]   in_sel,
    input  logic            in_bcast,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N*W-1:0]  out_data,
    output logic [CW-1:0]   drop_cnt,
    output logic            busy
);

    // One extra bit so the compare still works when N == 2**SW.
    localparam logic [SW:0] N_EXT = (SW+1)'(N);

    logic [N-1:0]  vld_q, vld_d;
    logic [W-1:0]  dat_q [N];
    logic [W-1:0]  dat_d [N];
    logic [CW-1:0] drop_q, drop_d;
    logic [N-1:0]  free;
    logic [N-1:0]  hit;
    logic          sel_ok;
    logic          sel_free;
    logic          accept;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign free[gi] = !vld_q[gi] | out_ready[gi];
            assign hit[gi]  = accept & (in_bcast | (sel_ok & (in_sel == SW'(gi))));
            assign out_data[gi*W +: W] = dat_q[gi];
        end
    endgenerate

    always_comb begin
        sel_ok   = ({1'b0, in_sel} < N_EXT);
        sel_free = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_sel == SW'(i)) begin
                sel_free = free[i];
            end
        end
        // No dependence on in_valid, so the producer may wait on in_ready.
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = sel_free;
        end else begin
            in_ready = 1'b1;
        end
        accept = in_valid & in_ready;
    end

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < N; i++) begin
            dat_d[i] = dat_q[i];
            if (hit[i]) begin
                vld_d[i] = 1'b1;
                dat_d[i] = in_data;
            end else if (out_ready[i]) begin
                vld_d[i] = 1'b0;
            end
        end

        drop_d = drop_q;
        if (accept && !in_bcast && !sel_ok && (drop_q != {CW{1'b1}})) begin
            drop_d = drop_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            drop_q <= '0;
            for (int i = 0; i < N; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            drop_q <= drop_d;
            for (int i = 0; i < N; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid = vld_q;
    assign drop_cnt  = drop_q;
    assign busy      = |vld_q;

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised successor to the basic 1:4 demux: routes one W-bit input stream to one of N output channels, or broadcasts it to all N.
- Every channel has valid/ready flow control and a one-entry output register.
- Sits between a single producer and N independent consumers. Consumers stall independently; a stall blocks only traffic addressed to that consumer.

Parameters:
- W, 8, data width in bits.
- N, 4, number of output channels (2..16).
- SW, 2, select width; must satisfy 2**SW >= N.
- CW, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid is also high.
- in_data  input  W  input payload.
- in_sel  input  SW  destination channel index.
- in_bcast  input  1  when 1, copy the beat to all N channels; in_sel is ignored.
- out_valid  output  N  per-channel valid; bit i belongs to channel i.
- out_ready  input  N  per-channel ready.
- out_data  output  N*W  flattened payload; channel i occupies bits [i*W +: W].
- drop_cnt  output  CW  count of beats dropped because in_sel >= N; saturates.
- busy  output  1  OR of out_valid.

Behaviour:
- Storage: each channel i holds a register vld[i] and dat[i]. out_valid[i] = vld[i] and out_data slice i = dat[i].
- Channel i can take a beat this cycle when free[i] = !vld[i] | out_ready[i], so a full slot that drains this cycle accepts a new beat in the same cycle.
- in_ready is combinational from in_bcast, in_sel, vld and out_ready. It has no path from in_valid or in_data.
  - in_bcast=1: in_ready = AND of free[0..N-1].
  - in_bcast=0 and in_sel < N: in_ready = free[in_sel].
  - in_bcast=0 and in_sel >= N: in_ready = 1. The beat is consumed and discarded.
- Accept is defined as in_valid & in_ready.
- Per-channel update on each clk edge, applied in this priority order:
  - rst: vld[i]=0 and dat[i]=0.
  - Accept targeting channel i: vld[i]=1, dat[i]=in_data.
  - Otherwise, if out_ready[i]: vld[i]=0. dat[i] holds its last value.
- Latency: a beat accepted at edge k is visible on out_valid/out_data immediately after edge k, i.e. one cycle.
- Throughput: one beat per cycle per channel when the consumer holds out_ready[i]=1 continuously.
- Broadcast is all-or-nothing. The beat is never written to only a subset of channels. If any channel is full and stalled, in_ready=0 and no channel is written.
- Ordering: beats reaching the same channel leave in acceptance order. No ordering is guaranteed across channels.
- Output stability: while out_valid[i]=1 and out_ready[i]=0, out_data slice i must not change.
- Drop counter:
  - drop_cnt increments by 1 on each accept with in_bcast=0 and in_sel >= N.
  - It saturates at 2**CW-1 and does not wrap.
  - It resets to 0.
  - When N = 2**SW the increment condition can never occur and drop_cnt stays 0.
- Reset:
  - All outputs reset to 0: out_valid, out_data, drop_cnt, busy.
  - in_ready evaluates to 1 during reset, because all slots are empty. Beats presented while rst=1 are discarded and not counted.
  - Reset mid-transfer discards held beats with no partial output.
- Simultaneous events: a channel draining (out_ready=1) and being refilled in the same cycle ends with vld=1 and the new data. No bubble is inserted and no beat is lost.
- Unknown or X on in_sel when in_valid=0 has no effect on state.

Test Plan:
- Reset/idle (N=4, W=8): assert rst for 2 cycles with in_valid=1, in_data=8'hFF → after release out_valid=4'b0000, drop_cnt=0, in_ready=1. No beat is delivered.
- Sweep select: out_ready=4'b1111; send in_data=8'hA0..A3 with in_sel=0..3 on consecutive cycles → out_valid is one-hot 0001, 0010, 0100, 1000 on successive cycles, each lagging by 1 cycle, with out_data slice = A0..A3. The original 1:4 pattern is preserved.
- Backpressure: out_ready[2]=0; send 8'h11 then 8'h22 to sel=2 → first accepted; second sees in_ready=0 and is held. Raise out_ready[2] → 8'h11 leaves and 8'h22 is accepted in the same cycle, then appears next cycle.
- Independent stall: out_ready=4'b1011 with channel 2 full; send to sel=0 → accepted while channel 2 stays blocked.
- Broadcast: in_bcast=1, in_data=8'h5A, all free → all four out_valid bits set with 8'h5A. Repeat with channel 3 full and stalled → in_ready=0 and no channel is written until channel 3 drains.
- Drop/saturation (N=3, SW=2, CW=2): send 5 beats with in_sel=3 → each accepted with in_ready=1, no out_valid. drop_cnt steps 1,2,3,3,3.
